// File: rtl/bit_sync.sv
// Purpose: per-bit multi-flop synchronizer bringing quasi-static level signals into the clk domain.
// Latency: NUM_STAGES rising edges from a stable input; NUM_STAGES+1 if captured inside the setup/hold window.
// Backpressure: none; every flop is clocked on every edge and there is no enable or bypass.
module bit_sync #(
    parameter int BUS_WIDTH  = 1,
    parameter int NUM_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] async,
    output logic [BUS_WIDTH-1:0] sync
);

    // A zero-width bus or a single flop would defeat the synchronizer, so refuse to elaborate.
    generate
        if (BUS_WIDTH < 1) begin : g_bad_width
            $error("bit_sync: BUS_WIDTH must be >= 1");
        end
        if (NUM_STAGES < 2) begin : g_bad_stages
            $error("bit_sync: NUM_STAGES must be >= 2");
        end
    endgenerate

    // stage[0] is the capture flop that may go metastable; later stages give it time to resolve.
    // Each bit travels its own column of this array, so bits resolve independently of one another.
    (* ASYNC_REG = "TRUE" *) logic [NUM_STAGES-1:0][BUS_WIDTH-1:0] stage;

    // Shift every bit one stage deeper per edge; reset clears the whole chain without a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage <= '0;
        end else begin
            stage <= {stage[NUM_STAGES-2:0], async};
        end
    end

    // Output straight from the last flop so no logic sits between the resolved value and its users.
    assign sync = stage[NUM_STAGES-1];

endmodule

// File: tb/tb_bit_sync.sv
// Bench for bit_sync: directed scenarios followed by randomized traffic with random mid-cycle resets.
// Expected values come from a history-of-samples model: sync equals the input sampled N edges ago.
// Two instances are exercised: 5 bits x 2 stages, and 1 bit x 3 stages.
module tb_bit_sync;

    logic       clk;
    logic       rst;
    logic [4:0] async5;
    logic [4:0] sync5;
    logic [0:0] async1;
    logic [0:0] sync1;

    int n_assert;
    int n_fail;

    // Sample histories since the last reset release, newest first.
    logic [4:0] hist5[$];
    logic [0:0] hist1[$];

    bit_sync #(.BUS_WIDTH(5), .NUM_STAGES(2)) dut5 (
        .clk   (clk),
        .rst   (rst),
        .async (async5),
        .sync  (sync5)
    );

    bit_sync #(.BUS_WIDTH(1), .NUM_STAGES(3)) dut3 (
        .clk   (clk),
        .rst   (rst),
        .async (async1),
        .sync  (sync1)
    );

    // 20 ns period, first rising edge at 10 ns.
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference: every edge out of reset records what the input was; reset forgets everything.
    always @(posedge clk) begin
        if (rst === 1'b1) begin
            hist5.push_front(async5);
            hist1.push_front(async1);
            if (hist5.size() > 4) void'(hist5.pop_back());
            if (hist1.size() > 4) void'(hist1.pop_back());
        end
    end

    always @(negedge rst) begin
        hist5.delete();
        hist1.delete();
    end

    // Output expected after N edges: the sample taken N edges ago, else 0 while the chain refills.
    function automatic logic [4:0] exp5();
        if (hist5.size() >= 2) return hist5[1];
        return 5'b00000;
    endfunction

    function automatic logic [0:0] exp1();
        if (hist1.size() >= 3) return hist1[2];
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic chk_both(input string tag);
        chk({tag, "_w5"}, sync5, exp5());
        chk({tag, "_w1"}, {4'b0000, sync1}, {4'b0000, exp1()});
    endtask

    // Advance to 5 ns after the next rising edge, where outputs are settled.
    task automatic edge_then_check(input string tag);
        @(posedge clk);
        #5;
        chk_both(tag);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        async5   = 5'b00000;
        async1   = 1'b0;

        // Reset and first propagation.
        #20 rst = 1'b0;
        #5;
        chk("reset_w5", sync5, 5'b00000);
        chk("reset_w1", {4'b0000, sync1}, 5'b00000);
        #15 rst = 1'b1;
        async5 = 5'b10101;
        @(posedge clk); #5;                        // 55 ns
        chk("first_edge50", sync5, 5'b00000);
        chk_both("first_edge50_model");
        @(posedge clk); #5;                        // 75 ns
        chk("first_edge70", sync5, 5'b10101);

        // Asynchronous reset between edges.
        #3 rst = 1'b0;                             // 78 ns
        #1;
        chk("midreset_immediate", sync5, 5'b00000);
        async5 = 5'b01010;
        #6 rst = 1'b1;                             // 85 ns
        edge_then_check("after_rel_e1");
        chk("after_rel_e1_const", sync5, 5'b00000);
        edge_then_check("after_rel_e2");
        chk("after_rel_e2_const", sync5, 5'b01010);

        // Single-bit latency with the other bits held.
        async5 = 5'b10100;
        for (int i = 0; i < 3; i++) edge_then_check("lat_settle");
        @(posedge clk);
        #3 async5 = 5'b10101;
        edge_then_check("lat_e1");
        chk("lat_e1_const", sync5, 5'b10100);
        edge_then_check("lat_e2");
        chk("lat_e2_const", sync5, 5'b10101);

        // Walking one, held four cycles per bit.
        for (int b = 0; b < 5; b++) begin
            async5 = 5'b00001 << b;
            for (int c = 0; c < 4; c++) begin
                edge_then_check("walk");
                if (c >= 1) chk("walk_onehot", sync5, 5'b00001 << b);
            end
        end

        // Three-stage instance: rise appears on the third edge after capture.
        async5 = 5'b00000;
        for (int i = 0; i < 4; i++) edge_then_check("ns3_settle");
        chk("ns3_low", {4'b0000, sync1}, 5'b00000);
        @(posedge clk);
        #3 async1 = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            edge_then_check("ns3_rise");
            chk("ns3_const", {4'b0000, sync1}, (e == 3) ? 5'b00001 : 5'b00000);
        end

        // Held all-ones for ten cycles: stable once through the chain.
        async5 = 5'b11111;
        for (int c = 0; c < 10; c++) begin
            edge_then_check("held");
            if (c >= 1) chk("held_const", sync5, 5'b11111);
        end

        // Randomized inputs with occasional reset pulses between edges.
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #3;
            async5 = 5'($urandom);
            async1 = 1'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                #4 rst = 1'b0;
                #2;
                chk("rand_reset_w5", sync5, 5'b00000);
                chk("rand_reset_w1", {4'b0000, sync1}, 5'b00000);
                #2 rst = 1'b1;
            end
            @(posedge clk);
            #5;
            chk_both("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
